stdout_hex_uart_tx: RTL and testbench
=====================================

Name: stdout_hex_uart_tx

Overview:
- Downstream consumer of the 16-bit stdio output stream, e.g. the stdout side of the stdio FIFO.
- Each accepted word is printed as four uppercase ASCII hex digits followed by a newline.
- Characters are sent on an 8N1 UART TX line, so the console shows one hex line per machine output word.
- Sits between the stdio buffering and the board's UART pin.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- BAUD, 115_200, UART bit rate.
- CPB (localparam), CLK_HZ/BAUD (integer divide), clocks per UART bit. Elaboration error if CPB < 2.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- rst_i  input  1  synchronous, active-high reset.
- stdin  stdio.in  val(1) in, rdy(1) out, data(16) in  word stream to print; handshake completes on val && rdy at a clock edge.
- tx_o  output  1  UART serial line, idle high.
- busy_o  output  1  high while a word is being serialised.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high. stdin uses the stdio valid/ready interface.
- Reset (edge with rst_i=1):
  - state=IDLE, tx_o=1, busy_o=0, stdin.rdy=1 after the reset edge.
  - All counters are cleared and any in-flight word is dropped.
  - Reset mid-character: tx_o returns to 1 on the reset edge. No further bits are sent.
- stdin.rdy = (state==IDLE). It is decoded from registered state only and never depends on stdin.val.
- Capture: at an edge with val && rdy:
  - Latch data into a 16-bit word register; char_idx=0; go to START.
  - tx_o drives 0 starting the cycle after capture.
  - stdin.data is not sampled at any other time; changes while rdy=0 are ignored.
- Character sequence, char_idx 0..4:
  - 0..3 are nibbles [15:12], [11:8], [7:4], [3:0].
  - 4 is 0x0A.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
- FSM states IDLE, START, DATA, STOP. baud_cnt counts 0..CPB-1; bit_idx counts 0..7.
  - IDLE: tx_o=1. On handshake go to START with baud_cnt=0.
  - START: tx_o=0 for CPB cycles, then go to DATA with bit_idx=0.
  - DATA: tx_o=char[bit_idx], LSB first, each bit held CPB cycles. After bit 7, go to STOP.
  - STOP: tx_o=1 for CPB cycles. If char_idx<4: char_idx++ and go to START. Else go to IDLE.
- Timing:
  - One character = 10*CPB cycles; one word = 50*CPB cycles of line activity.
  - rdy reasserts in the cycle after the final stop bit's last cycle.
  - With val held high, the next capture occurs on that cycle's edge. Back-to-back start bits are therefore 50*CPB+1 cycles apart (one idle-high cycle between words).
- busy_o = (state != IDLE). busy_o and tx_o are registered, with no glitches.
- Counter widths: baud_cnt uses $clog2(CPB) bits; bit_idx 3 bits; char_idx 3 bits. There is no wrap outside the stated ranges.

Test Plan (CLK_HZ=16, BAUD=4 -> CPB=4):
- Reset: rst_i=1 for 2 cycles, val=0 -> tx_o=1, rdy=1, busy_o=0 on every cycle after the first reset edge.
- Word 0x1A2F:
  - Decoded line bytes 0x31,0x41,0x32,0x46,0x0A, each with start=0 and stop=1.
  - Each bit is exactly 4 cycles; frame is 200 cycles.
  - rdy=0 and busy_o=1 for all 200 cycles.
- Words 0x0000 then 0xFFFF -> "0000\n" then "FFFF\n" (0x30x4,0x0A then 0x46x4,0x0A).
- Back-to-back: val held high with 0x0009 then 0xBEEF -> second start-bit falling edge is exactly 201 cycles after the first. Output is "0009\n" then "BEEF\n".
- Data change while busy:
  - Capture 0x1234, then change data to 0xDEAD with val=1 mid-frame.
  - Output remains "1234\n"; 0xDEAD is accepted only when rdy returns.
- Reset mid-operation:
  - Assert rst_i during the DATA bits of the 2nd character.
  - tx_o=1 from the reset edge onward and no further characters are sent.
  - After release, a new word 0x00A0 prints "00A0\n" correctly.

Source files
------------

// File: rtl/stdout_hex_uart_tx.sv
// stdout_hex_uart_tx
// This module prints each 16-bit stdio word as four uppercase ASCII hex digits
// followed by a newline (0x0A). The characters go out on an 8N1 UART TX line.
// A word is accepted only while the serialiser is idle. The line and busy
// outputs are registered, so they do not glitch.

module stdout_hex_uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // stdio input stream (valid/ready)
    input  logic        stdin_val,
    output logic        stdin_rdy,
    input  logic [15:0] stdin_data,
    // UART line and activity flag
    output logic        tx_o,
    output logic        busy_o
);

    // Clocks per UART bit.
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

    // The bit timer needs at least two clocks per bit.
    if (CPB < 2) begin : g_cpb_check
        $error("stdout_hex_uart_tx: CLK_HZ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [15:0]      word;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       char_idx;

    logic [7:0]       cur_char;
    logic [2:0]       next_bit;
    logic             bit_end;

    // Map a nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Ready depends only on registered state, never on stdin_val.
    assign stdin_rdy = (state == IDLE);

    assign bit_end  = (baud_cnt == CNT_LAST);
    assign next_bit = bit_idx + 3'd1;

    // Select the character being sent: four nibbles MSB first, then newline.
    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            3'd0:    cur_char = hex_ascii(word[15:12]);
            3'd1:    cur_char = hex_ascii(word[11:8]);
            3'd2:    cur_char = hex_ascii(word[7:4]);
            3'd3:    cur_char = hex_ascii(word[3:0]);
            default: cur_char = 8'h0A;
        endcase
    end

    // Serialiser FSM. The line value is registered together with each state
    // change, so tx_o always reflects the bit of the current cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            word     <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    if (stdin_val) begin
                        word     <= stdin_data;
                        char_idx <= '0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= START;
                        tx_o     <= 1'b0;
                        busy_o   <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_o     <= cur_char[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= next_bit;
                            tx_o    <= cur_char[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (char_idx < 3'd4) begin
                            char_idx <= char_idx + 3'd1;
                            state    <= START;
                            tx_o     <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tx_o   <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_hex_uart_tx.sv
// Testbench for stdout_hex_uart_tx with CLK_HZ=16 and BAUD=4, so CPB=4.
// DUT outputs are sampled on the falling clock edge. Inputs are also changed
// on the falling edge.

module tb_stdout_hex_uart_tx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stdin_val;
    logic        stdin_rdy;
    logic [15:0] stdin_data;
    logic        tx_o;
    logic        busy_o;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    stdout_hex_uart_tx #(.CLK_HZ(16), .BAUD(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .stdin_val  (stdin_val),
        .stdin_rdy  (stdin_rdy),
        .stdin_data (stdin_data),
        .tx_o       (tx_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receive one 8N1 frame.
    // On entry the bench sits at an unconsumed falling-edge sample. On exit it
    // sits at the first sample after the stop bit. The errs output counts bad
    // framing samples and samples with busy/rdy not in their busy state.
    task automatic rx_byte(output logic [7:0] b, output int errs, output int start_cyc);
        int waited;
        waited    = 0;
        errs      = 0;
        b         = '0;
        start_cyc = cyc;
        while (tx_o !== 1'b0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 1000) begin
            errs = 1000;
            return;
        end
        start_cyc = cyc;
        for (int s = 0; s < 4; s++) begin
            if (tx_o !== 1'b0) errs++;
            if (busy_o !== 1'b1 || stdin_rdy !== 1'b0) errs++;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            b[i] = tx_o;
            for (int s = 0; s < 4; s++) begin
                if (tx_o !== b[i]) errs++;
                if (busy_o !== 1'b1 || stdin_rdy !== 1'b0) errs++;
                @(negedge clk);
            end
        end
        for (int s = 0; s < 4; s++) begin
            if (tx_o !== 1'b1) errs++;
            if (busy_o !== 1'b1 || stdin_rdy !== 1'b0) errs++;
            @(negedge clk);
        end
    endtask

    // Receive a full five-character line.
    task automatic rx_word(output logic [39:0] line, output int errs, output int start_cyc);
        logic [7:0] b;
        int e;
        int sc;
        line = '0;
        errs = 0;
        start_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            rx_byte(b, e, sc);
            if (k == 0) start_cyc = sc;
            line = {line[31:0], b};
            errs += e;
        end
    endtask

    // Present a word for one cycle while the DUT is idle.
    task automatic send_word(input logic [15:0] d);
        stdin_val  = 1'b1;
        stdin_data = d;
        @(negedge clk);
        stdin_val  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        stdin_val  = 1'b0;
        stdin_data = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            assertions++;
            if (tx_o !== 1'b1 || stdin_rdy !== 1'b1 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cycle %0d: tx=%b rdy=%b busy=%b, expected tx=1 rdy=1 busy=0",
                         k, tx_o, stdin_rdy, busy_o);
            end
        end
        rst_i = 1'b0;
        @(negedge clk);
        assertions++;
        if (tx_o !== 1'b1 || stdin_rdy !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: tx=%b rdy=%b busy=%b, expected tx=1 rdy=1 busy=0",
                     tx_o, stdin_rdy, busy_o);
        end
        @(negedge clk);
    endtask

    task automatic test_word(input logic [15:0] d, input logic [39:0] exp_line, input string name);
        logic [39:0] line;
        int errs;
        int sc;
        assertions++;
        if (stdin_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s_rdy_before: rdy=%b, expected 1", name, stdin_rdy);
        end
        send_word(d);
        rx_word(line, errs, sc);
        assertions++;
        if (line !== exp_line) begin
            failures++;
            $display("FAIL %s_line: got %h, expected %h", name, line, exp_line);
        end
        assertions++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL %s_framing: %0d bad samples, expected 0", name, errs);
        end
        assertions++;
        if (stdin_rdy !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle_after: rdy=%b busy=%b tx=%b, expected 1 0 1",
                     name, stdin_rdy, busy_o, tx_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] line;
        int errs;
        int sc1;
        int sc2;
        stdin_val  = 1'b1;
        stdin_data = 16'h0009;
        @(negedge clk);
        stdin_data = 16'hBEEF;
        rx_word(line, errs, sc1);
        assertions++;
        if (line !== 40'h30_30_30_39_0A || errs !== 0) begin
            failures++;
            $display("FAIL b2b_first: line=%h errs=%0d, expected 303030390a errs=0", line, errs);
        end
        // This is the idle cycle. The held valid is captured on the next edge.
        @(negedge clk);
        stdin_val = 1'b0;
        rx_word(line, errs, sc2);
        assertions++;
        if (line !== 40'h42_45_45_46_0A || errs !== 0) begin
            failures++;
            $display("FAIL b2b_second: line=%h errs=%0d, expected 424545460a errs=0", line, errs);
        end
        assertions++;
        if (sc2 - sc1 !== 201) begin
            failures++;
            $display("FAIL b2b_spacing: start bits %0d cycles apart, expected 201", sc2 - sc1);
        end
    endtask

    task automatic test_data_change_busy();
        logic [7:0] b;
        logic [39:0] line;
        int e;
        int errs;
        int sc;
        send_word(16'h1234);
        line = '0;
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                stdin_val  = 1'b1;
                stdin_data = 16'hDEAD;
            end
            rx_byte(b, e, sc);
            line = {line[31:0], b};
            errs += e;
        end
        assertions++;
        if (line !== 40'h31_32_33_34_0A || errs !== 0) begin
            failures++;
            $display("FAIL busy_change_line: line=%h errs=%0d, expected 313233340a errs=0", line, errs);
        end
        assertions++;
        if (stdin_rdy !== 1'b1) begin
            failures++;
            $display("FAIL busy_change_rdy: rdy=%b, expected 1", stdin_rdy);
        end
        @(negedge clk);
        stdin_val = 1'b0;
        rx_word(line, errs, sc);
        assertions++;
        if (line !== 40'h44_45_41_44_0A || errs !== 0) begin
            failures++;
            $display("FAIL busy_change_dead: line=%h errs=%0d, expected 444541440a errs=0", line, errs);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [39:0] line;
        int e;
        int sc;
        int waited;
        int lows;
        send_word(16'h5A5A);
        rx_byte(b, e, sc);
        assertions++;
        if (b !== 8'h35 || e !== 0) begin
            failures++;
            $display("FAIL rst_mid_char0: got %h errs=%0d, expected 35 errs=0", b, e);
        end
        waited = 0;
        while (tx_o !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        // Move past the start bit into data bit 2 of the second character.
        for (int s = 0; s < 14; s++) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        assertions++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || stdin_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_state: tx=%b busy=%b rdy=%b, expected 1 0 1", tx_o, busy_o, stdin_rdy);
        end
        rst_i = 1'b0;
        lows  = 0;
        for (int s = 0; s < 80; s++) begin
            if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
            @(negedge clk);
        end
        assertions++;
        if (lows !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: %0d active samples after reset, expected 0", lows);
        end
        test_word(16'h00A0, 40'h30_30_41_30_0A, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word(16'h1A2F, 40'h31_41_32_46_0A, "word_1a2f");
        test_word(16'h0000, 40'h30_30_30_30_0A, "word_0000");
        test_word(16'hFFFF, 40'h46_46_46_46_0A, "word_ffff");
        test_back_to_back();
        test_data_change_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
